iiitb_fifo_uart_tx: RTL and testbench

- Downstream drain stage for the 8-bit iiitb_fifo.
- Pulls one byte at a time from the FIFO read port and serialises it as an asynchronous UART frame: start bit, 8 data bits LSB first, optional even-parity bit, stop bit.
- Guarantees it never reads an empty FIFO, so the FIFO underflow flag can never be raised by this block.
- Provides frame-done and byte-count status to the host.

---
 rtl/iiitb_fifo_uart_tx.sv | 160 ++++++++++++++++
 tb/tb_iiitb_fifo_uart_tx.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_fifo_uart_tx.sv
// UART transmitter that drains bytes from iiitb_fifo: start, 8 data bits LSB first,
// optional even parity, stop. A read is only issued when the FIFO reports non-empty.
module iiitb_fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] bytes_sent
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state, state_nxt;
  logic        tx_nxt, rd_nxt, busy_nxt, done_nxt;
  logic [15:0] bytes_nxt;
  logic [15:0] baud_cnt, baud_nxt;
  logic [2:0]  bit_idx, idx_nxt;
  logic [7:0]  shift, shift_nxt;
  logic        parity_bit, parity_nxt;
  logic        bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx         <= 1'b1;
      fifo_rd    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      bytes_sent <= 16'd0;
      baud_cnt   <= 16'd0;
      bit_idx    <= 3'd0;
      shift      <= 8'd0;
      parity_bit <= 1'b0;
    end else begin
      state      <= state_nxt;
      tx         <= tx_nxt;
      fifo_rd    <= rd_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
      bytes_sent <= bytes_nxt;
      baud_cnt   <= baud_nxt;
      bit_idx    <= idx_nxt;
      shift      <= shift_nxt;
      parity_bit <= parity_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    tx_nxt     = tx;
    rd_nxt     = 1'b0;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    bytes_nxt  = bytes_sent;
    baud_nxt   = baud_cnt;
    idx_nxt    = bit_idx;
    shift_nxt  = shift;
    parity_nxt = parity_bit;

    case (state)
      IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        if (en && !fifo_empty) begin
          rd_nxt    = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = REQ;
        end
      end
      // The FIFO pops on this edge; its new data_out is valid during LOAD.
      REQ: state_nxt = LOAD;
      LOAD: begin
        shift_nxt  = fifo_data;
        parity_nxt = ^fifo_data;
        tx_nxt     = 1'b0;
        baud_nxt   = 16'd0;
        idx_nxt    = 3'd0;
        state_nxt  = START;
      end
      START: begin
        if (bit_end) begin
          baud_nxt  = 16'd0;
          tx_nxt    = shift[0];
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_nxt  = 16'd0;
          shift_nxt = {1'b0, shift[7:1]};
          idx_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            if (PARITY_EN) begin
              tx_nxt    = parity_bit;
              state_nxt = PARITY;
            end else begin
              tx_nxt    = 1'b1;
              state_nxt = STOP;
            end
          end else begin
            // shift[1] becomes shift[0] at this same edge
            tx_nxt = shift[1];
          end
        end else begin
          baud_nxt = baud_cnt + 16'd1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          baud_nxt  = 16'd0;
          tx_nxt    = 1'b1;
          state_nxt = STOP;
        end else begin
          baud_nxt = baud_cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_nxt  = 16'd0;
          done_nxt  = 1'b1;
          bytes_nxt = bytes_sent + 16'd1;
          if (en && !fifo_empty) begin
            rd_nxt    = 1'b1;
            busy_nxt  = 1'b1;
            state_nxt = REQ;
          end else begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end else begin
          baud_nxt = baud_cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_iiitb_fifo_uart_tx.sv
// Bench for iiitb_fifo_uart_tx: two instances (CLKS_PER_BIT=4 no parity, CLKS_PER_BIT=2 even parity)
// each fed by a behavioural FIFO; tx waveforms are compared cycle by cycle to a frame model.
module tb_iiitb_fifo_uart_tx;

  localparam int CPB_A = 4;
  localparam int CPB_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic        fifo_empty_a = 1'b1, fifo_empty_b = 1'b1;
  logic [7:0]  fifo_data_a = 8'd0, fifo_data_b = 8'd0;
  logic        fifo_rd_a, tx_a, busy_a, fd_a;
  logic        fifo_rd_b, tx_b, busy_b, fd_b;
  logic [15:0] bs_a, bs_b;

  logic        wr_a = 1'b0, wr_b = 1'b0;
  logic [7:0]  wd_a = 8'd0, wd_b = 8'd0;
  logic [7:0]  qa[$], qb[$];
  logic        uf_a = 1'b0, uf_b = 1'b0;
  int          rd_cnt_a = 0, rd_cnt_b = 0;

  int          checks = 0, errors = 0;
  logic [15:0] exp_bs_a = 16'd0, exp_bs_b = 16'd0;

  logic        cap_tx[0:63], cap_fd[0:63], cap_busy[0:63];
  logic [15:0] cap_bs[0:63];

  iiitb_fifo_uart_tx #(.CLKS_PER_BIT(CPB_A), .PARITY_EN(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .fifo_empty(fifo_empty_a), .fifo_data(fifo_data_a),
    .fifo_rd(fifo_rd_a), .tx(tx_a), .busy(busy_a), .frame_done(fd_a), .bytes_sent(bs_a));

  iiitb_fifo_uart_tx #(.CLKS_PER_BIT(CPB_B), .PARITY_EN(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .fifo_empty(fifo_empty_b), .fifo_data(fifo_data_b),
    .fifo_rd(fifo_rd_b), .tx(tx_b), .busy(busy_b), .frame_done(fd_b), .bytes_sent(bs_b));

  // Behavioural FIFOs: registered data_out/empty, underflow sticky flag.
  always @(posedge clk) begin
    if (wr_a) qa.push_back(wd_a);
    if (fifo_rd_a) begin
      rd_cnt_a <= rd_cnt_a + 1;
      if (qa.size() == 0) uf_a <= 1'b1;
      else fifo_data_a <= qa.pop_front();
    end
    fifo_empty_a <= (qa.size() == 0);
  end

  always @(posedge clk) begin
    if (wr_b) qb.push_back(wd_b);
    if (fifo_rd_b) begin
      rd_cnt_b <= rd_cnt_b + 1;
      if (qb.size() == 0) uf_b <= 1'b1;
      else fifo_data_b <= qb.pop_front();
    end
    fifo_empty_b <= (qb.size() == 0);
  end

  // Expected line level k cycles after tx falls: start, data LSB first, parity, stop, then idle high.
  function automatic logic model_tx(input logic [7:0] b, input bit par, input int cpb, input int k);
    int slot = k / cpb;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (par && slot == 9) return ^b;
    return 1'b1;
  endfunction

  function automatic logic get_tx(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction

  task automatic push(input bit sel, input logic [7:0] b);
    if (sel) begin wr_b = 1'b1; wd_b = b; end
    else begin wr_a = 1'b1; wd_a = b; end
    @(negedge clk);
    wr_a = 1'b0;
    wr_b = 1'b0;
  endtask

  task automatic wait_start(input bit sel, output int gap, output bit tmo);
    gap = 0;
    tmo = 1'b0;
    while (get_tx(sel) !== 1'b0) begin
      if (gap >= 200) begin
        tmo = 1'b1;
        break;
      end
      @(negedge clk);
      gap++;
    end
  endtask

  task automatic capture(input bit sel, input int n, input int off);
    for (int i = 0; i < n; i++) begin
      cap_tx[off+i]   = sel ? tx_b : tx_a;
      cap_fd[off+i]   = sel ? fd_b : fd_a;
      cap_busy[off+i] = sel ? busy_b : busy_a;
      cap_bs[off+i]   = sel ? bs_b : bs_a;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    push(1'b0, 8'hA5);
    en_a = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({tx_a, fifo_rd_a, busy_a, fd_a} !== 4'b1000 || bs_a !== 16'd0) begin
        errors++;
        $display("FAIL reset_outputs tx=%b rd=%b busy=%b fd=%b bytes=%0d required 1 0 0 0 0",
                 tx_a, fifo_rd_a, busy_a, fd_a, bs_a);
      end
    end
    checks++;
    if (rd_cnt_a !== 0) begin
      errors++;
      $display("FAIL reset_no_read reads=%0d required 0", rd_cnt_a);
    end
  endtask

  task automatic test_single_byte();
    int r0, gap;
    bit tmo;
    logic m;
    r0 = rd_cnt_a;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({fifo_rd_a, busy_a, tx_a} !== 3'b111) begin
      errors++;
      $display("FAIL single_req rd/busy/tx=%b%b%b required 111", fifo_rd_a, busy_a, tx_a);
    end
    @(negedge clk);
    checks++;
    if ({fifo_rd_a, tx_a} !== 2'b01) begin
      errors++;
      $display("FAIL single_load rd/tx=%b%b required 01", fifo_rd_a, tx_a);
    end
    wait_start(1'b0, gap, tmo);
    checks++;
    if (tmo || gap != 1) begin
      errors++;
      $display("FAIL single_tx_fall gap=%0d timeout=%0b required gap 1", gap, tmo);
    end
    capture(1'b0, 41, 0);
    exp_bs_a = exp_bs_a + 16'd1;
    for (int k = 0; k < 40; k++) begin
      m = model_tx(8'hA5, 1'b0, CPB_A, k);
      checks++;
      if ({cap_tx[k], cap_fd[k], cap_busy[k]} !== {m, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL single_frame cyc=%0d tx/fd/busy=%b%b%b required %b01",
                 k, cap_tx[k], cap_fd[k], cap_busy[k], m);
      end
    end
    checks++;
    if ({cap_tx[40], cap_fd[40], cap_busy[40]} !== 3'b110 || cap_bs[40] !== exp_bs_a) begin
      errors++;
      $display("FAIL single_end tx/fd/busy=%b%b%b bytes=%0d required 110 bytes=%0d",
               cap_tx[40], cap_fd[40], cap_busy[40], cap_bs[40], exp_bs_a);
    end
    checks++;
    if (rd_cnt_a - r0 != 1) begin
      errors++;
      $display("FAIL single_reads reads=%0d required 1", rd_cnt_a - r0);
    end
  endtask

  task automatic test_empty();
    en_a = 1'b1;
    repeat (200) begin
      @(negedge clk);
      checks++;
      if ({fifo_rd_a, tx_a, busy_a} !== 3'b010) begin
        errors++;
        $display("FAIL empty_idle rd/tx/busy=%b%b%b required 010", fifo_rd_a, tx_a, busy_a);
      end
    end
  endtask

  task automatic test_back_to_back(input logic [7:0] data[$], input string name);
    int r0, gap, n;
    bit tmo;
    logic m;
    n = data.size();
    en_a = 1'b0;
    foreach (data[i]) push(1'b0, data[i]);
    r0 = rd_cnt_a;
    en_a = 1'b1;
    for (int f = 0; f < n; f++) begin
      wait_start(1'b0, gap, tmo);
      // After a capture, samples 40 and 41 were the two idle-high cycles between frames.
      checks++;
      if (tmo || gap != ((f == 0) ? 3 : 1)) begin
        errors++;
        $display("FAIL %s_gap frame=%0d gap=%0d timeout=%0b required %0d",
                 name, f, gap, tmo, (f == 0) ? 3 : 1);
      end
      capture(1'b0, 41, 0);
      exp_bs_a = exp_bs_a + 16'd1;
      for (int k = 0; k < 42 && k < 40; k++) begin
        m = model_tx(data[f], 1'b0, CPB_A, k);
        checks++;
        if ({cap_tx[k], cap_fd[k], cap_busy[k]} !== {m, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL %s_frame byte=%0d cyc=%0d tx/fd/busy=%b%b%b required %b01",
                   name, f, k, cap_tx[k], cap_fd[k], cap_busy[k], m);
        end
      end
      checks++;
      if ({cap_tx[40], cap_fd[40], cap_busy[40]} !== {2'b11, (f < n - 1)} || cap_bs[40] !== exp_bs_a) begin
        errors++;
        $display("FAIL %s_end byte=%0d tx/fd/busy=%b%b%b bytes=%0d required 11%b bytes=%0d",
                 name, f, cap_tx[40], cap_fd[40], cap_busy[40], cap_bs[40], (f < n - 1), exp_bs_a);
      end
    end
    checks++;
    if (rd_cnt_a - r0 != n || uf_a !== 1'b0) begin
      errors++;
      $display("FAIL %s_reads reads=%0d underflow=%b required %0d and 0", name, rd_cnt_a - r0, uf_a, n);
    end
  endtask

  task automatic test_parity();
    logic [7:0] data[2];
    int gap, r0;
    bit tmo;
    logic m;
    data[0] = 8'h07;
    data[1] = 8'h03;
    push(1'b1, data[0]);
    push(1'b1, data[1]);
    r0 = rd_cnt_b;
    en_b = 1'b1;
    for (int f = 0; f < 2; f++) begin
      wait_start(1'b1, gap, tmo);
      checks++;
      if (tmo || gap != ((f == 0) ? 3 : 1)) begin
        errors++;
        $display("FAIL parity_gap frame=%0d gap=%0d timeout=%0b", f, gap, tmo);
      end
      capture(1'b1, 23, 0);
      exp_bs_b = exp_bs_b + 16'd1;
      for (int k = 0; k < 22; k++) begin
        m = model_tx(data[f], 1'b1, CPB_B, k);
        checks++;
        if ({cap_tx[k], cap_fd[k], cap_busy[k]} !== {m, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL parity_frame byte=%0d cyc=%0d tx/fd/busy=%b%b%b required %b01",
                   f, k, cap_tx[k], cap_fd[k], cap_busy[k], m);
        end
      end
      checks++;
      if ({cap_tx[18], cap_tx[19]} !== ((f == 0) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL parity_bit byte=%0d bit=%b%b required %0d", f, cap_tx[18], cap_tx[19], (f == 0) ? 1 : 0);
      end
      checks++;
      if ({cap_tx[22], cap_fd[22]} !== 2'b11 || cap_bs[22] !== exp_bs_b) begin
        errors++;
        $display("FAIL parity_end byte=%0d tx/fd=%b%b bytes=%0d required 11 bytes=%0d",
                 f, cap_tx[22], cap_fd[22], cap_bs[22], exp_bs_b);
      end
    end
    en_b = 1'b0;
    checks++;
    if (rd_cnt_b - r0 != 2 || uf_b !== 1'b0) begin
      errors++;
      $display("FAIL parity_reads reads=%0d underflow=%b required 2 and 0", rd_cnt_b - r0, uf_b);
    end
  endtask

  task automatic test_en_drop_reset();
    logic [7:0] b0, b1;
    int r0, gap;
    bit tmo;
    logic m;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    en_a = 1'b0;
    push(1'b0, b0);
    push(1'b0, b1);
    r0 = rd_cnt_a;
    en_a = 1'b1;
    wait_start(1'b0, gap, tmo);
    checks++;
    if (tmo || gap != 3) begin
      errors++;
      $display("FAIL drop_start gap=%0d timeout=%0b required 3", gap, tmo);
    end
    // Sample 18 lies in data bit 3.
    capture(1'b0, 18, 0);
    en_a = 1'b0;
    capture(1'b0, 23, 18);
    exp_bs_a = exp_bs_a + 16'd1;
    for (int k = 0; k < 40; k++) begin
      m = model_tx(b0, 1'b0, CPB_A, k);
      checks++;
      if ({cap_tx[k], cap_fd[k], cap_busy[k]} !== {m, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL drop_frame cyc=%0d tx/fd/busy=%b%b%b required %b01",
                 k, cap_tx[k], cap_fd[k], cap_busy[k], m);
      end
    end
    checks++;
    if ({cap_fd[40], cap_busy[40]} !== 2'b10 || cap_bs[40] !== exp_bs_a) begin
      errors++;
      $display("FAIL drop_end fd/busy=%b%b bytes=%0d required 10 bytes=%0d",
               cap_fd[40], cap_busy[40], cap_bs[40], exp_bs_a);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (rd_cnt_a - r0 != 1 || tx_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL drop_no_read reads=%0d tx=%b busy=%b required 1 1 0", rd_cnt_a - r0, tx_a, busy_a);
    end
    en_a = 1'b1;
    wait_start(1'b0, gap, tmo);
    checks++;
    if (tmo || gap != 3) begin
      errors++;
      $display("FAIL rst_start gap=%0d timeout=%0b required 3", gap, tmo);
    end
    // Sample 26 lies in data bit 5; the reset edge follows it.
    capture(1'b0, 26, 0);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx_a, fd_a, busy_a, fifo_rd_a} !== 4'b1000 || bs_a !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_frame tx/fd/busy/rd=%b%b%b%b bytes=%0d required 1000 bytes=0",
               tx_a, fd_a, busy_a, fifo_rd_a, bs_a);
    end
    exp_bs_a = 16'd0;
    for (int k = 0; k < 26; k++) begin
      m = model_tx(b1, 1'b0, CPB_A, k);
      checks++;
      if ({cap_tx[k], cap_fd[k]} !== {m, 1'b0}) begin
        errors++;
        $display("FAIL rst_partial cyc=%0d tx/fd=%b%b required %b0", k, cap_tx[k], cap_fd[k], m);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (rd_cnt_a - r0 != 2 || uf_a !== 1'b0 || tx_a !== 1'b1 || bs_a !== exp_bs_a) begin
      errors++;
      $display("FAIL rst_after reads=%0d underflow=%b tx=%b bytes=%0d required 2 0 1 0",
               rd_cnt_a - r0, uf_a, tx_a, bs_a);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d[$];
    repeat (2) @(negedge clk);
    test_reset();
    test_single_byte();
    test_empty();
    d.push_back(8'h01);
    d.push_back(8'h02);
    d.push_back(8'h03);
    test_back_to_back(d, "b2b");
    d.delete();
    for (int i = 0; i < 4; i++) d.push_back(8'($urandom));
    test_back_to_back(d, "rand");
    test_parity();
    test_en_drop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
